awb_gain_ctrl: RTL and testbench
================================

# awb_gain_ctrl

Gray-world auto-white-balance controller that sequences the white-balance gain registers. It observes the same Bayer pixel stream that feeds the white-balance stage and accumulates per-channel sums and counts over one frame. At frame end it derives the R/G/B gains with a shared sequential divider, then commits them atomically. Its K_R/K_G/K_B/valid_gain_o outputs drive the white-balance stage's gain inputs directly.

## Interface
- CNT_W, 20, per-channel pixel-count width; max 2^CNT_W−1 pixels per channel per frame
- DIV_W, CNT_W+8, divider width (sum width)

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- en_i  in  1  AWB enable; 0 = no accumulation, gains held
- valid_i  in  1  pixel valid
- color_i  in  2  0=R, 1=G, 2=B, 3=ignored
- value_i  in  8  pixel value
- last_i  in  1  last pixel of frame (qualified by valid_i)
- K_R, K_G, K_B  out  16  gains, unsigned Q8.8 (0x0100 = 1.0), clamped to 0x0FFF
- valid_gain_o  out  1  gains valid
- update_o  out  1  one-cycle pulse on gain commit
- overrun_o  out  1  one-cycle pulse when frame statistics are dropped

## Operation
- Accumulate on valid_i & en_i & color_i≠3: sum_c += value_i, cnt_c += 1.
  - A channel whose cnt_c is at its maximum stops accumulating (sum and count freeze).
- Frame end on valid_i & en_i & last_i. The last pixel is included.
  - If FSM is IDLE: snapshot sums/counts into compute registers, clear accumulators, start computing.
  - If FSM is busy: discard, clear accumulators, pulse overrun_o. The running computation continues.
- The next frame accumulates while computing.
- FSM states: IDLE → MEAN (c=R,G,B; mean_c = sum_c / cnt_c, 8-bit) → GAIN (c=R,B; K_c = (mean_G<<8)/mean_c) → COMMIT → IDLE.
- Arithmetic edge cases:
  - cnt_c = 0 → mean_c = 0, no divide launched (same cycle count).
  - mean_c = 0 with mean_G ≠ 0 → K_c = 0x0FFF.
  - mean_G = 0 → K_R = K_B = 0x0100.
  - Quotient > 0x0FFF → 0x0FFF.
  - K_G is always 0x0100.
- COMMIT writes K_R, K_G, K_B in one cycle and pulses update_o.
- en_i = 0 does not abort a computation in progress.

## Timing
- Reset values:
  - K_R = K_G = K_B = 0x0100
  - valid_gain_o = 0
  - update_o = 0, overrun_o = 0
  - accumulators = 0, FSM IDLE
- valid_gain_o goes to 1 on the first clock after reset release and stays 1. Gains are never torn.
- Each divide slot takes DIV_W+1 cycles: 1 launch + DIV_W restoring iterations, one quotient bit per cycle.
- Frame-end latency: last pixel sampled at edge t → snapshot at t+1 → new gains visible and update_o high at t+2+5·(DIV_W+1). Defaults give t+147.
- Pixel acceptance is unconditional. There is no back-pressure.
- Reset mid-computation: all state returns to reset values and gains return to unity; no update_o.

## Structure
- Shared package `awb_pkg`:
  - color codes RED/GREEN/BLUE
  - GAIN_UNITY = 16'h0100, GAIN_MAX = 16'h0FFF
  - FSM state enum
- One sub-module `awb_div`:
  - unsigned restoring divider, parameter W
  - ports: start, dividend, divisor, quotient, done
  - done pulses W cycles after start
  - divisor 0 → quotient all ones

## Test plan
- Reset → K_* = 0x0100, valid_gain_o = 0 then 1 next cycle, no pulses.
- Frame of 4 R=64, 8 G=128, 4 B=32, last on final B → update_o at t+147; K_R = 0x0200, K_G = 0x0100, K_B = 0x0400.
- Frame with G=255 ×2, R=255 ×1, B=4 ×1 → K_B clamped 0x0FFF, K_R = 0x0100.
- Frame with no B pixels, R=G=100 → K_B = 0x0FFF, K_R = 0x0100. Frame with only color 3 → all unity.
- Second last_i 20 cycles after the first → overrun_o pulse; first frame's gains still committed at t+147; the following frame computes normally.
- rst_n low at t+60 of a computation → gains unity, no update_o. With en_i = 0, a full frame with last_i → no computation, gains unchanged.

Source files
------------

// File: rtl/awb_pkg.sv
// Shared definitions for the gray-world auto-white-balance controller.
// Colour codes, gain constants, FSM state type and gain clamping helper.
package awb_pkg;

  localparam logic [1:0] RED   = 2'd0;
  localparam logic [1:0] GREEN = 2'd1;
  localparam logic [1:0] BLUE  = 2'd2;

  localparam logic [15:0] GAIN_UNITY = 16'h0100;
  localparam logic [15:0] GAIN_MAX   = 16'h0FFF;

  typedef enum logic [1:0] {
    StIdle,
    StMean,
    StGain,
    StCommit
  } awb_state_e;

  function automatic logic [15:0] clamp_gain(input logic [31:0] q);
    return (q > 32'(GAIN_MAX)) ? GAIN_MAX : q[15:0];
  endfunction

endpackage

// File: rtl/awb_gain_ctrl_if.sv
// Bayer pixel stream observed by the AWB controller.
interface awb_gain_ctrl_if;
  logic       valid_i;
  logic [1:0] color_i;
  logic [7:0] value_i;
  logic       last_i;

  modport master (output valid_i, color_i, value_i, last_i);
  modport slave  (input  valid_i, color_i, value_i, last_i);
endinterface

// File: rtl/awb_div.sv
// Unsigned restoring divider: one quotient bit per cycle, done pulses W cycles after start.
// A zero divisor yields an all-ones quotient.
module awb_div #(
  parameter int unsigned W = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int unsigned CntW = $clog2(W + 1);

  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dsor_q, dsor_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W:0]      rem_sh;

  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsor_d = dsor_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dsor_d = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (rem_sh >= {1'b0, dsor_q}) begin
        rem_d = W'(rem_sh - {1'b0, dsor_q});
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntW'(W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsor_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsor_q <= dsor_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/awb_gain_ctrl.sv
// Gray-world AWB controller: accumulates per-channel statistics per frame, then derives
// R/B gains with one shared divider over five fixed-length slots and commits them atomically.
module awb_gain_ctrl
  import awb_pkg::*;
#(
  parameter int unsigned CNT_W = 20,
  parameter int unsigned DIV_W = CNT_W + 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  awb_gain_ctrl_if.slave        pix,
  output logic [15:0]           K_R,
  output logic [15:0]           K_G,
  output logic [15:0]           K_B,
  output logic                  valid_gain_o,
  output logic                  update_o,
  output logic                  overrun_o
);
  localparam int unsigned SlotW = $clog2(DIV_W + 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(DIV_W);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [DIV_W-1:0] sum_q [3], sum_d [3], csum_q [3];
  logic [CNT_W-1:0] cnt_q [3], cnt_d [3], ccnt_q [3];
  logic [7:0]       mean_q [3], mean_d [3];
  logic             frame_end_q, snap;

  awb_state_e       state_q, state_d;
  logic [1:0]       chan_q, chan_d, dst_chan_q, dst_chan_d;
  logic             dst_gain_q, dst_gain_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [15:0]      kr_q, kr_d, kb_q, kb_d, gain_r_q, gain_r_d, gain_b_q, gain_b_d;
  logic             update_d, update_q, overrun_q, valid_gain_q;

  logic             div_start, div_done;
  logic [DIV_W-1:0] div_dividend, div_divisor, div_quo, sel_sum;
  logic [CNT_W-1:0] sel_cnt;
  logic [7:0]       sel_mean;

  assign snap = frame_end_q && (state_q == StIdle);

  // A frame end clears the accumulators one cycle later; that cycle's pixel opens the new frame.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sum_d[c] = frame_end_q ? '0 : sum_q[c];
      cnt_d[c] = frame_end_q ? '0 : cnt_q[c];
      if (pix.valid_i && en_i && (pix.color_i == 2'(c)) && (cnt_d[c] != CntMax)) begin
        sum_d[c] = sum_d[c] + DIV_W'(pix.value_i);
        cnt_d[c] = cnt_d[c] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    sel_sum  = '0;
    sel_cnt  = '0;
    sel_mean = '0;
    for (int c = 0; c < 3; c++) begin
      if (chan_q == 2'(c)) begin
        sel_sum  = csum_q[c];
        sel_cnt  = ccnt_q[c];
        sel_mean = mean_q[c];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    slot_d       = slot_q;
    dst_chan_d   = dst_chan_q;
    dst_gain_d   = dst_gain_q;
    mean_d       = mean_q;
    kr_d         = kr_q;
    kb_d         = kb_q;
    gain_r_d     = gain_r_q;
    gain_b_d     = gain_b_q;
    update_d     = 1'b0;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;

    // Result of the previous slot lands in the first cycle of the next slot (or COMMIT).
    if (div_done) begin
      if (dst_gain_q) begin
        if (dst_chan_q == RED) kr_d = clamp_gain(32'(div_quo));
        else                   kb_d = clamp_gain(32'(div_quo));
      end else begin
        for (int c = 0; c < 3; c++) begin
          if (dst_chan_q == 2'(c)) mean_d[c] = div_quo[7:0];
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (snap) begin
          state_d = StMean;
          chan_d  = RED;
          slot_d  = '0;
        end
      end
      StMean, StGain: begin
        if (slot_q == '0) begin
          dst_chan_d = chan_q;
          dst_gain_d = (state_q == StGain);
          if (state_q == StMean) begin
            if (sel_cnt == '0) begin
              for (int c = 0; c < 3; c++) begin
                if (chan_q == 2'(c)) mean_d[c] = 8'h00;
              end
            end else begin
              div_start    = 1'b1;
              div_dividend = sel_sum;
              div_divisor  = DIV_W'(sel_cnt);
            end
          end else if (mean_q[GREEN] == 8'h00 || sel_mean == 8'h00) begin
            if (chan_q == RED) kr_d = (mean_q[GREEN] == 8'h00) ? GAIN_UNITY : GAIN_MAX;
            else               kb_d = (mean_q[GREEN] == 8'h00) ? GAIN_UNITY : GAIN_MAX;
          end else begin
            div_start    = 1'b1;
            div_dividend = DIV_W'({mean_q[GREEN], 8'h00});
            div_divisor  = DIV_W'(sel_mean);
          end
        end
        if (slot_q == SlotLast) begin
          slot_d = '0;
          if (state_q == StMean) begin
            if (chan_q == BLUE) begin
              state_d = StGain;
              chan_d  = RED;
            end else begin
              chan_d = chan_q + 2'd1;
            end
          end else if (chan_q == RED) begin
            chan_d = BLUE;
          end else begin
            state_d = StCommit;
          end
        end else begin
          slot_d = slot_q + SlotW'(1);
        end
      end
      StCommit: begin
        gain_r_d = kr_d;
        gain_b_d = kb_d;
        update_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  awb_div #(
    .W(DIV_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .quotient(div_quo),
    .done    (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        sum_q[c]  <= '0;
        cnt_q[c]  <= '0;
        csum_q[c] <= '0;
        ccnt_q[c] <= '0;
        mean_q[c] <= '0;
      end
      frame_end_q  <= 1'b0;
      state_q      <= StIdle;
      chan_q       <= RED;
      slot_q       <= '0;
      dst_chan_q   <= RED;
      dst_gain_q   <= 1'b0;
      kr_q         <= GAIN_UNITY;
      kb_q         <= GAIN_UNITY;
      gain_r_q     <= GAIN_UNITY;
      gain_b_q     <= GAIN_UNITY;
      update_q     <= 1'b0;
      overrun_q    <= 1'b0;
      valid_gain_q <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        sum_q[c]  <= sum_d[c];
        cnt_q[c]  <= cnt_d[c];
        mean_q[c] <= mean_d[c];
        if (snap) begin
          csum_q[c] <= sum_q[c];
          ccnt_q[c] <= cnt_q[c];
        end
      end
      frame_end_q  <= pix.valid_i & en_i & pix.last_i;
      state_q      <= state_d;
      chan_q       <= chan_d;
      slot_q       <= slot_d;
      dst_chan_q   <= dst_chan_d;
      dst_gain_q   <= dst_gain_d;
      kr_q         <= kr_d;
      kb_q         <= kb_d;
      gain_r_q     <= gain_r_d;
      gain_b_q     <= gain_b_d;
      update_q     <= update_d;
      overrun_q    <= frame_end_q && (state_q != StIdle);
      valid_gain_q <= 1'b1;
    end
  end

  assign K_R          = gain_r_q;
  assign K_G          = GAIN_UNITY;
  assign K_B          = gain_b_q;
  assign valid_gain_o = valid_gain_q;
  assign update_o     = update_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Directed bench for awb_gain_ctrl: table of frames with hand-computed gains plus
// sequences for reset, overrun, mid-computation reset and disabled accumulation.
module tb_awb_gain_ctrl;

  typedef struct {
    string      name;
    int         nr;
    logic [7:0] vr;
    int         ng;
    logic [7:0] vg;
    int         nb;
    logic [7:0] vb;
    int         nx;
    logic [15:0] exp_kr;
    logic [15:0] exp_kb;
  } frame_vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b1;
  logic [15:0] k_r, k_g, k_b;
  logic        valid_gain, update, overrun;
  int          checks = 0;
  int          errors = 0;

  awb_gain_ctrl_if pix ();

  awb_gain_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .pix         (pix),
    .K_R         (k_r),
    .K_G         (k_g),
    .K_B         (k_b),
    .valid_gain_o(valid_gain),
    .update_o    (update),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one pixel for exactly one sampling edge, returns 1 time unit after that edge.
  task automatic pixel(input logic [1:0] c, input logic [7:0] v, input logic l);
    @(negedge clk);
    pix.valid_i = 1'b1;
    pix.color_i = c;
    pix.value_i = v;
    pix.last_i  = l;
    @(posedge clk);
    #1;
    pix.valid_i = 1'b0;
    pix.last_i  = 1'b0;
  endtask

  task automatic send_frame(input frame_vec_t v);
    int total;
    int idx;
    total = v.nr + v.ng + v.nb + v.nx;
    idx = 0;
    for (int i = 0; i < v.nr; i++) begin pixel(2'd0, v.vr, idx == total - 1); idx++; end
    for (int i = 0; i < v.ng; i++) begin pixel(2'd1, v.vg, idx == total - 1); idx++; end
    for (int i = 0; i < v.nb; i++) begin pixel(2'd2, v.vb, idx == total - 1); idx++; end
    for (int i = 0; i < v.nx; i++) begin pixel(2'd3, 8'd77, idx == total - 1); idx++; end
  endtask

  // Called just after the edge that sampled the last pixel (edge t).
  task automatic expect_commit(input string name, input logic [15:0] kr, input logic [15:0] kb);
    int early;
    early = 0;
    for (int k = 1; k <= 146; k++) begin
      @(posedge clk);
      #1;
      if (update) early++;
    end
    check({name, " early update"}, early, 0);
    @(posedge clk);
    #1;
    check({name, " update at t+147"}, update, 1);
    check({name, " K_R"}, k_r, kr);
    check({name, " K_G"}, k_g, 16'h0100);
    check({name, " K_B"}, k_b, kb);
  endtask

  task automatic expect_no_commit(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (update) seen++;
    end
    check({name, " no update"}, seen, 0);
  endtask

  frame_vec_t vecs [8];

  initial begin
    int ovr_seen;
    int upd_seen;

    vecs[0] = '{"basic",      4, 64,  8, 128, 4, 32,  0, 16'h0200, 16'h0400};
    vecs[1] = '{"clamp_b",    1, 255, 2, 255, 1, 4,   0, 16'h0100, 16'h0FFF};
    vecs[2] = '{"no_blue",    2, 100, 2, 100, 0, 0,   0, 16'h0100, 16'h0FFF};
    vecs[3] = '{"only_ign",   0, 0,   0, 0,   0, 0,   3, 16'h0100, 16'h0100};
    vecs[4] = '{"half_gain",  1, 200, 1, 100, 1, 50,  0, 16'h0080, 16'h0200};
    vecs[5] = '{"no_green",   1, 10,  0, 0,   0, 0,   0, 16'h0100, 16'h0100};
    vecs[6] = '{"fraction",   3, 90,  2, 60,  4, 45,  1, 16'h00AA, 16'h0155};
    vecs[7] = '{"clamp_r",    1, 1,   1, 255, 1, 255, 0, 16'h0FFF, 16'h0100};

    pix.valid_i = 1'b0;
    pix.color_i = 2'd0;
    pix.value_i = 8'd0;
    pix.last_i  = 1'b0;

    // Reset state
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset K_R", k_r, 16'h0100);
    check("reset K_G", k_g, 16'h0100);
    check("reset K_B", k_b, 16'h0100);
    check("reset valid_gain", valid_gain, 0);
    check("reset update", update, 0);
    check("reset overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("valid_gain before first edge", valid_gain, 0);
    @(posedge clk);
    #1;
    check("valid_gain after first edge", valid_gain, 1);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i]);
      expect_commit(vecs[i].name, vecs[i].exp_kr, vecs[i].exp_kb);
      repeat (3) @(posedge clk);
    end

    // Overrun: second frame end 20 cycles after the first
    send_frame(vecs[0]);
    ovr_seen = 0;
    upd_seen = 0;
    for (int k = 1; k <= 146; k++) begin
      if (k == 20) begin
        pix.valid_i = 1'b1;
        pix.color_i = 2'd1;
        pix.value_i = 8'd9;
        pix.last_i  = 1'b1;
      end
      @(posedge clk);
      #1;
      pix.valid_i = 1'b0;
      pix.last_i  = 1'b0;
      if (overrun) ovr_seen++;
      if (update) upd_seen++;
      if (k == 21) check("overrun pulse at t+21", overrun, 1);
    end
    check("overrun pulse count", ovr_seen, 1);
    check("overrun early update", upd_seen, 0);
    @(posedge clk);
    #1;
    check("overrun commit update", update, 1);
    check("overrun commit K_R", k_r, 16'h0200);
    check("overrun commit K_B", k_b, 16'h0400);
    repeat (3) @(posedge clk);
    send_frame(vecs[4]);
    expect_commit("after overrun", 16'h0080, 16'h0200);

    // Reset in the middle of a computation
    repeat (3) @(posedge clk);
    send_frame(vecs[0]);
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset K_R", k_r, 16'h0100);
    check("midreset K_B", k_b, 16'h0100);
    check("midreset valid_gain", valid_gain, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_commit("midreset", 150);
    check("midreset K_R held", k_r, 16'h0100);
    check("midreset K_B held", k_b, 16'h0100);
    check("midreset valid_gain back", valid_gain, 1);

    // Disabled: frame with last_i must not start a computation
    send_frame(vecs[0]);
    expect_commit("pre-disable", 16'h0200, 16'h0400);
    en = 1'b0;
    send_frame(vecs[4]);
    expect_no_commit("disabled", 150);
    check("disabled K_R held", k_r, 16'h0200);
    check("disabled K_B held", k_b, 16'h0400);
    en = 1'b1;
    send_frame(vecs[4]);
    expect_commit("re-enabled", 16'h0080, 16'h0200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
